// File: rtl/mod_n_updown_counter.sv
// mod_n_updown_counter: synchronous modulo-N up/down counter with load, cascade tc and sticky ovf.
// Ports: clk, rst (sync active-low), en, up, load, din[WIDTH], clr_ovf -> q[WIDTH], tc (comb), ovf (sticky).
// Optional macro COUNTER_SATURATE_EN: saturate at the terminal value instead of wrapping.
module mod_n_updown_counter #(
  parameter int     WIDTH   = 4,
  parameter longint MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  logic             at_end;
  logic [WIDTH-1:0] next_q;
  // Equality compare against MAX keeps the wrap correct when MODULUS < 2**WIDTH.
  assign at_end = up ? (q == MAX) : (q == '0);
  assign tc     = rst & en & ~load & at_end;
`ifdef COUNTER_SATURATE_EN
  assign next_q = at_end ? q : (up ? q + 1'b1 : q - 1'b1);
`else
  assign next_q = at_end ? (up ? '0 : MAX) : (up ? q + 1'b1 : q - 1'b1);
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      q   <= '0;
      ovf <= 1'b0;
    end else begin
      if (load) q <= (din > MAX) ? MAX : din;
      else if (en) q <= next_q;
      // tc marks a wrap (or a blocked saturating step); it wins over clr_ovf.
      if (tc) ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end
endmodule
